shift_receiver: RTL and testbench



---
 rtl/shift_link_pkg.sv | 18 +
 rtl/shift_rx_counter.sv | 46 ++++
 rtl/shift_receiver.sv | 164 ++++++++++++++++
 tb/tb_shift_receiver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_link_pkg.sv
// Types, defaults and helpers shared by both ends of the MSB-first serial link
// (shifter transmitter and shift_receiver).
package shift_link_pkg;

   localparam int SHIFT_WIDTH_DEFAULT = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      HOLD = 2'd2
   } shift_state_e;

   // Even parity over up to 64 data bits; callers zero-extend narrower words.
   function automatic logic even_parity(input logic [63:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/shift_rx_counter.sv
// Bit counter for shift_receiver: synchronous clear, load-1, increment and a
// flag marking the count at which the next accepted bit ends the frame.
module shift_rx_counter
   import shift_link_pkg::*;
#(
   parameter int CNT_W = 5,
   parameter int LAST  = 23
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load1,
   input  logic inc,
   output logic at_last
);

   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear wins over load, load wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (load1) begin
         cnt_d = CNT_W'(1);
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_last = (cnt_q == LAST_C);

endmodule

// File: rtl/shift_receiver.sv
// Bit-serial to parallel deserializer with a valid/ready word output.
// Optional macro SHIFT_RX_PARITY_EN adds a trailing even-parity bit and parity_err.
module shift_receiver
   import shift_link_pkg::*;
#(
   parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_bit,
   input  logic             in_valid,
   input  logic             start,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
`ifdef SHIFT_RX_PARITY_EN
   output logic             parity_err,
`endif
   output logic             overrun
);

`ifdef SHIFT_RX_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   shift_state_e     state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;
`ifdef SHIFT_RX_PARITY_EN
   logic             parity_err_q, parity_err_d;
`endif

   logic             cnt_clr_s, cnt_load1_s, cnt_inc_s, cnt_last_s;
   logic             frame_start_s;
   logic [WIDTH-1:0] first_word_s, next_word_s;

   assign frame_start_s = in_valid & start;
   assign first_word_s  = {{(WIDTH-1){1'b0}}, in_bit};
   assign next_word_s   = {shift_q[WIDTH-2:0], in_bit};

   shift_rx_counter #(
      .CNT_W (CNT_W),
      .LAST  (FRAME_LEN - 1)
   ) u_counter (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr_s),
      .load1   (cnt_load1_s),
      .inc     (cnt_inc_s),
      .at_last (cnt_last_s)
   );

   // Next-state, datapath and counter control.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      overrun_d    = 1'b0;
      cnt_clr_s    = 1'b0;
      cnt_load1_s  = 1'b0;
      cnt_inc_s    = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      parity_err_d = parity_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (frame_start_s) begin
               state_d     = RECV;
               shift_d     = first_word_s;
               cnt_load1_s = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         RECV: begin
            if (frame_start_s) begin
               // Resync: the aborted frame is dropped without output.
               shift_d     = first_word_s;
               cnt_load1_s = 1'b1;
            end else if (in_valid) begin
               if (cnt_last_s) begin
                  state_d      = HOLD;
                  data_valid_d = 1'b1;
                  cnt_clr_s    = 1'b1;
`ifdef SHIFT_RX_PARITY_EN
                  data_out_d   = shift_q;
                  parity_err_d = even_parity(64'(shift_q)) ^ in_bit;
`else
                  data_out_d   = next_word_s;
`endif
               end else begin
                  shift_d   = next_word_s;
                  cnt_inc_s = 1'b1;
               end
            end else begin
               state_d = RECV;
            end
         end
         HOLD: begin
            if (data_ready) begin
               data_valid_d = 1'b0;
               if (frame_start_s) begin
                  state_d     = RECV;
                  shift_d     = first_word_s;
                  cnt_load1_s = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (frame_start_s) begin
               overrun_d = 1'b1;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d      = IDLE;
            data_valid_d = 1'b0;
            cnt_clr_s    = 1'b1;
         end
      endcase
      busy_d = (state_d == RECV);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= {WIDTH{1'b0}};
         data_out_q   <= {WIDTH{1'b0}};
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
`ifdef SHIFT_RX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;
`ifdef SHIFT_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_shift_receiver.sv
// Directed self-checking bench for shift_receiver (default and SHIFT_RX_PARITY_EN builds).
module tb_shift_receiver;

   localparam int W = 24;
`ifdef SHIFT_RX_PARITY_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_bit = 1'b0;
   logic         in_valid = 1'b0;
   logic         start = 1'b0;
   logic         data_ready = 1'b0;
   logic [W-1:0] data_out;
   logic         data_valid;
   logic         busy;
   logic         overrun;
`ifdef SHIFT_RX_PARITY_EN
   logic         parity_err;
   logic         par_flip = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_receiver #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_bit     (in_bit),
      .in_valid   (in_valid),
      .start      (start),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
`ifdef SHIFT_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .overrun    (overrun)
   );

   task automatic drive(input logic b, input logic s, input logic v);
      in_bit   = b;
      start    = s;
      in_valid = v;
      @(posedge clk);
      #1;
   endtask

   // Sends one full frame MSB first; counts busy, early data_valid and overrun cycles.
   task automatic send_frame(input logic [W-1:0] w, input bit stall,
                             input logic rdy_first, input logic rdy_rest,
                             output int busy_cnt, output int early_dv, output int ovr_cnt);
      busy_cnt = 0;
      early_dv = 0;
      ovr_cnt  = 0;
      for (int i = FRAME - 1; i >= 0; i--) begin
         logic b;
`ifdef SHIFT_RX_PARITY_EN
         b = (i == 0) ? ((^w) ^ par_flip) : w[i-1];
`else
         b = w[i];
`endif
         data_ready = (i == FRAME - 1) ? rdy_first : rdy_rest;
         drive(b, (i == FRAME - 1), 1'b1);
         if (overrun) ovr_cnt++;
         if (i > 0) begin
            if (busy) busy_cnt++;
            if (data_valid) early_dv++;
            if (stall) begin
               drive(1'b0, 1'b0, 1'b0);
               if (busy) busy_cnt++;
               if (data_valid) early_dv++;
               if (overrun) ovr_cnt++;
            end
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      data_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b1);
      checks++;
      if ({data_out, data_valid, busy, overrun} !== {24'h000000, 3'b000}) begin
         errors++;
         $display("FAIL reset_outputs: got %h/%b/%b/%b expected 000000/0/0/0", data_out, data_valid, busy, overrun);
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_basic();
      int bc, ed, ov;
      send_frame(24'h157C7F, 1'b0, 1'b1, 1'b1, bc, ed, ov);
      checks++;
      if ({data_valid, busy} !== 2'b10 || data_out !== 24'h157C7F) begin
         errors++;
         $display("FAIL basic_word: got dv=%b busy=%b data=%h expected dv=1 busy=0 data=157c7f", data_valid, busy, data_out);
      end
      checks++;
      if (bc !== FRAME - 1 || ed !== 0) begin
         errors++;
         $display("FAIL basic_timing: got busy_cycles=%0d early_valid=%0d expected %0d and 0", bc, ed, FRAME - 1);
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (data_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_accept: got dv=%b expected 0", data_valid);
      end
   endtask

   task automatic test_stall();
      int bc, ed, ov;
      data_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignore: got busy=%b expected 0", busy);
      end
      send_frame(24'h157C7F, 1'b1, 1'b0, 1'b0, bc, ed, ov);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 24'h157C7F || ed !== 0) begin
         errors++;
         $display("FAIL stall_word: got dv=%b data=%h early=%0d expected 1 157c7f 0", data_valid, data_out, ed);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b0);
         checks++;
         if (data_valid !== 1'b1 || data_out !== 24'h157C7F) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got dv=%b data=%h expected 1 157c7f", k, data_valid, data_out);
         end
      end
      data_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (data_valid !== 1'b0 || data_out !== 24'h157C7F) begin
         errors++;
         $display("FAIL stall_release: got dv=%b data=%h expected 0 157c7f", data_valid, data_out);
      end
   endtask

   task automatic test_back_to_back();
      int bc, ed, ov;
      send_frame(24'hA5A5A5, 1'b0, 1'b0, 1'b0, bc, ed, ov);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 24'hA5A5A5 || ov !== 0) begin
         errors++;
         $display("FAIL b2b_first: got dv=%b data=%h ovr=%0d expected 1 a5a5a5 0", data_valid, data_out, ov);
      end
      send_frame(24'h00FFFF, 1'b0, 1'b1, 1'b0, bc, ed, ov);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 24'h00FFFF || ov !== 0 || ed !== 0 || bc !== FRAME - 1) begin
         errors++;
         $display("FAIL b2b_second: got dv=%b data=%h ovr=%0d early=%0d busy=%0d expected 1 00ffff 0 0 %0d",
                  data_valid, data_out, ov, ed, bc, FRAME - 1);
      end
      data_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      data_ready = 1'b0;
   endtask

   task automatic test_overrun();
      int bc, ed, ov;
      send_frame(24'hFFFFFF, 1'b0, 1'b0, 1'b0, bc, ed, ov);
      drive(1'b1, 1'b1, 1'b1);
      checks++;
      if ({overrun, data_valid, busy} !== 3'b110 || data_out !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL overrun_pulse: got ovr=%b dv=%b busy=%b data=%h expected 1 1 0 ffffff", overrun, data_valid, busy, data_out);
      end
      drive(1'b0, 1'b0, 1'b1);
      checks++;
      if ({overrun, data_valid, busy} !== 3'b010 || data_out !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL overrun_after: got ovr=%b dv=%b busy=%b data=%h expected 0 1 0 ffffff", overrun, data_valid, busy, data_out);
      end
      data_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (data_valid !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_drain: got dv=%b ovr=%b expected 0 0", data_valid, overrun);
      end
      data_ready = 1'b0;
   endtask

   task automatic test_resync();
      int bc, ed, ov;
      logic [W-1:0] junk;
      junk = 24'hABCDEF;
      for (int i = W - 1; i >= W - 10; i--) begin
         drive(junk[i], (i == W - 1), 1'b1);
      end
      checks++;
      if (busy !== 1'b1 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL resync_partial: got busy=%b dv=%b expected 1 0", busy, data_valid);
      end
      send_frame(24'h123456, 1'b0, 1'b0, 1'b0, bc, ed, ov);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 24'h123456 || ed !== 0 || bc !== FRAME - 1) begin
         errors++;
         $display("FAIL resync_word: got dv=%b data=%h early=%0d busy=%0d expected 1 123456 0 %0d",
                  data_valid, data_out, ed, bc, FRAME - 1);
      end
      data_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      data_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int bc, ed, ov;
      logic [W-1:0] w;
      w = 24'h5A5A5A;
      for (int i = W - 1; i > W - 13; i--) begin
         drive(w[i], (i == W - 1), 1'b1);
      end
      rst = 1'b1;
      drive(w[W-13], 1'b0, 1'b1);
      checks++;
      if ({data_out, data_valid, busy, overrun} !== {24'h000000, 3'b000}) begin
         errors++;
         $display("FAIL reset_mid: got %h/%b/%b/%b expected 000000/0/0/0", data_out, data_valid, busy, overrun);
      end
      rst = 1'b0;
      send_frame(24'h000001, 1'b0, 1'b0, 1'b0, bc, ed, ov);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 24'h000001 || bc !== FRAME - 1) begin
         errors++;
         $display("FAIL reset_recover: got dv=%b data=%h busy=%0d expected 1 000001 %0d", data_valid, data_out, bc, FRAME - 1);
      end
      data_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      data_ready = 1'b0;
   endtask

`ifdef SHIFT_RX_PARITY_EN
   task automatic test_parity();
      int bc, ed, ov;
      par_flip = 1'b1;
      send_frame(24'h000003, 1'b0, 1'b0, 1'b0, bc, ed, ov);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 24'h000003 || parity_err !== 1'b1) begin
         errors++;
         $display("FAIL parity_bad: got dv=%b data=%h perr=%b expected 1 000003 1", data_valid, data_out, parity_err);
      end
      data_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      data_ready = 1'b0;
      par_flip = 1'b0;
      send_frame(24'h000003, 1'b0, 1'b0, 1'b0, bc, ed, ov);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 24'h000003 || parity_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_good: got dv=%b data=%h perr=%b expected 1 000003 0", data_valid, data_out, parity_err);
      end
      data_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      data_ready = 1'b0;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2;
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_overrun();
      test_resync();
      test_reset_mid();
`ifdef SHIFT_RX_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
